// File: rtl/vpu_pkg.sv
// Shared VPU command definitions: opcodes, op encodings, command struct and the decode function.
package vpu_pkg;

  localparam logic [4:0] OpcDraw    = 5'b10000;
  localparam logic [4:0] OpcElli    = 5'b10001;
  localparam logic [4:0] OpcFill    = 5'b10010;
  localparam logic [4:0] OpcRmv     = 5'b10011;
  localparam logic [4:0] OpcTran    = 5'b10100;
  localparam logic [4:0] OpcRot     = 5'b10101;
  localparam logic [4:0] OpcScale   = 5'b10110;
  localparam logic [4:0] OpcReflect = 5'b10111;
  localparam logic [4:0] OpcMat     = 5'b11000;
  localparam logic [4:0] OpcGetobj  = 5'b11001;

  localparam logic [3:0] OpDraw    = 4'h0;
  localparam logic [3:0] OpRmvOne  = 4'h1;
  localparam logic [3:0] OpRmvAll  = 4'h2;
  localparam logic [3:0] OpTranA   = 4'h3;
  localparam logic [3:0] OpTranB   = 4'h4;
  localparam logic [3:0] OpScale   = 4'h5;
  localparam logic [3:0] OpRotB    = 4'h6;
  localparam logic [3:0] OpRotA    = 4'h7;
  localparam logic [3:0] OpReflX   = 4'h8;
  localparam logic [3:0] OpReflY   = 4'h9;
  localparam logic [3:0] OpReflXy  = 4'hA;
  localparam logic [3:0] OpMatA    = 4'hB;
  localparam logic [3:0] OpMatB    = 4'hC;
  localparam logic [3:0] OpGetobj  = 4'hF;

  typedef struct packed {
    logic       fill;
    logic [3:0] op;
    logic [3:0] code;
    logic [1:0] obj_type;
    logic [2:0] obj_color;
    logic [4:0] obj_num;
  } vpu_cmd_t;

  function automatic vpu_cmd_t vpu_decode(input logic [15:0] instr);
    vpu_cmd_t c;
    c.fill      = 1'b0;
    c.op        = OpDraw;
    c.code      = {instr[1:0], instr[3:2]};
    c.obj_type  = instr[10:9];
    c.obj_color = instr[2:0];
    c.obj_num   = instr[9:5];
    case (instr[15:11])
      OpcDraw, OpcElli: c.op = OpDraw;
      OpcFill:          c.fill = 1'b1;
      OpcRmv:           c.op = instr[10] ? OpRmvAll : OpRmvOne;
      OpcTran:          c.op = instr[10] ? OpTranB : OpTranA;
      OpcRot: begin
        c.op   = instr[10] ? OpRotB : OpRotA;
        c.code = instr[3:0];
      end
      OpcScale: begin
        c.op   = OpScale;
        c.code = instr[3:0];
      end
      OpcReflect: begin
        case (instr[1:0])
          2'd1:    c.op = OpReflX;
          2'd2:    c.op = OpReflY;
          default: c.op = OpReflXy;
        endcase
      end
      OpcMat:    c.op = instr[10] ? OpMatB : OpMatA;
      OpcGetobj: c.op = OpGetobj;
      default:   c.op = OpDraw;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/vpu_instr_decode.sv
// Single decode site for VPU instructions; shared by the queue and the CPU hazard logic.
module vpu_instr_decode
  import vpu_pkg::*;
(
  input  logic [15:0] instr,
  output vpu_cmd_t    cmd
);

  assign cmd = vpu_decode(instr);

endmodule

// File: rtl/vpu_cmd_queue.sv
// DEPTH-entry command FIFO between CPU issue and the VPU, with show-ahead registered head,
// flush and sticky overflow.
module vpu_cmd_queue
  import vpu_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned NUM_V  = 8,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          STALL,
  input  logic                          VPU_start,
  input  logic [15:0]                   VPU_instr,
  input  logic [(NUM_V+1)*DATA_W-1:0]   V_in,
  input  logic                          flush,
  input  logic                          cmd_ready,
  output logic                          cmd_valid,
  output logic                          cmd_fill,
  output logic [3:0]                    cmd_op,
  output logic [3:0]                    cmd_code,
  output logic [1:0]                    cmd_obj_type,
  output logic [2:0]                    cmd_obj_color,
  output logic [4:0]                    cmd_obj_num,
  output logic [(NUM_V+1)*DATA_W-1:0]   V_out,
  output logic                          queue_full,
  output logic [$clog2(DEPTH+1)-1:0]    count,
  output logic                          overflow
);

  localparam int unsigned VW = (NUM_V + 1) * DATA_W;
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  vpu_cmd_t in_cmd;

  vpu_instr_decode u_decode (
    .instr (VPU_instr),
    .cmd   (in_cmd)
  );

  vpu_cmd_t        cmd_mem_q [DEPTH];
  logic [VW-1:0]   v_mem_q   [DEPTH];

  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, rd_ptr_nxt;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  vpu_cmd_t      head_cmd_q, head_cmd_d;
  logic [VW-1:0] head_v_q, head_v_d;
  logic          is_full, push, pop, push_ok;

  assign is_full    = (count_q == CW'(DEPTH));
  assign cmd_valid  = (count_q != '0);
  assign push       = VPU_start & ~STALL & ~flush;
  assign pop        = cmd_valid & cmd_ready & ~flush;
  // A full queue still accepts when the head leaves in the same cycle.
  assign push_ok    = push & (~is_full | pop);
  assign rd_ptr_nxt = rd_ptr_q + PW'(1);

  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    head_cmd_d = head_cmd_q;
    head_v_d   = head_v_q;
    if (flush) begin
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end else begin
      if (pop)              rd_ptr_d = rd_ptr_nxt;
      if (push_ok)          wr_ptr_d = wr_ptr_q + PW'(1);
      if (push && !push_ok) overflow_d = 1'b1;
      count_d = count_q + CW'(push_ok) - CW'(pop);
      // The head register is the show-ahead view; it bypasses storage when the pushed entry
      // becomes head directly, otherwise it loads the successor on a pop.
      if (push_ok && (count_q == '0 || (pop && count_q == CW'(1)))) begin
        head_cmd_d = in_cmd;
        head_v_d   = V_in;
      end else if (pop && count_q > CW'(1)) begin
        head_cmd_d = cmd_mem_q[rd_ptr_nxt];
        head_v_d   = v_mem_q[rd_ptr_nxt];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      head_cmd_q <= '0;
      head_v_q   <= '0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      head_cmd_q <= head_cmd_d;
      head_v_q   <= head_v_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      cmd_mem_q[wr_ptr_q] <= in_cmd;
      v_mem_q[wr_ptr_q]   <= V_in;
    end
  end

  assign cmd_fill      = head_cmd_q.fill;
  assign cmd_op        = head_cmd_q.op;
  assign cmd_code      = head_cmd_q.code;
  assign cmd_obj_type  = head_cmd_q.obj_type;
  assign cmd_obj_color = head_cmd_q.obj_color;
  assign cmd_obj_num   = head_cmd_q.obj_num;
  assign V_out         = head_v_q;
  assign queue_full    = is_full;
  assign count         = count_q;
  assign overflow      = overflow_q;

endmodule

// File: tb/tb_vpu_cmd_queue.sv
// Self-checking bench for vpu_cmd_queue: directed scenarios plus randomized traffic against a
// queue-based reference model.
module tb_vpu_cmd_queue;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned NUM_V  = 8;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned VW     = (NUM_V + 1) * DATA_W;
  localparam int unsigned CW     = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [18:0]   f;
    logic [VW-1:0] v;
  } entry_t;

  logic          clk = 1'b0;
  logic          rst_n, STALL, VPU_start, flush, cmd_ready;
  logic [15:0]   VPU_instr;
  logic [VW-1:0] V_in;
  logic          cmd_valid, cmd_fill, queue_full, overflow;
  logic [3:0]    cmd_op, cmd_code;
  logic [1:0]    cmd_obj_type;
  logic [2:0]    cmd_obj_color;
  logic [4:0]    cmd_obj_num;
  logic [VW-1:0] V_out;
  logic [CW-1:0] count;

  int n_checks = 0;
  int n_fail   = 0;

  entry_t exp_q[$];
  entry_t last;
  logic   exp_ovf;

  vpu_cmd_queue #(.DATA_W(DATA_W), .NUM_V(NUM_V), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .STALL         (STALL),
    .VPU_start     (VPU_start),
    .VPU_instr     (VPU_instr),
    .V_in          (V_in),
    .flush         (flush),
    .cmd_ready     (cmd_ready),
    .cmd_valid     (cmd_valid),
    .cmd_fill      (cmd_fill),
    .cmd_op        (cmd_op),
    .cmd_code      (cmd_code),
    .cmd_obj_type  (cmd_obj_type),
    .cmd_obj_color (cmd_obj_color),
    .cmd_obj_num   (cmd_obj_num),
    .V_out         (V_out),
    .queue_full    (queue_full),
    .count         (count),
    .overflow      (overflow)
  );

  always #5 clk = ~clk;

  // {fill, op, code, obj_type, obj_color, obj_num} derived straight from the instruction rules.
  function automatic logic [18:0] ref_decode(input logic [15:0] i);
    logic       fill;
    logic [3:0] op;
    logic [3:0] code;
    int         opc;
    fill = 1'b0;
    op   = 4'd0;
    code = {i[1:0], i[3:2]};
    opc  = int'(i[15:11]);
    if (opc == 18) fill = 1'b1;
    else if (opc == 19) op = i[10] ? 4'd2 : 4'd1;
    else if (opc == 20) op = i[10] ? 4'd4 : 4'd3;
    else if (opc == 21) begin op = i[10] ? 4'd6 : 4'd7; code = i[3:0]; end
    else if (opc == 22) begin op = 4'd5; code = i[3:0]; end
    else if (opc == 23) op = (i[1:0] == 2'd1) ? 4'd8 : (i[1:0] == 2'd2) ? 4'd9 : 4'd10;
    else if (opc == 24) op = i[10] ? 4'd12 : 4'd11;
    else if (opc == 25) op = 4'd15;
    return {fill, op, code, i[10:9], i[2:0], i[9:5]};
  endfunction

  function automatic logic [VW-1:0] rand_v();
    logic [VW-1:0] v;
    for (int w = 0; w < int'(NUM_V + 1); w++) v[w*DATA_W +: DATA_W] = DATA_W'($urandom);
    return v;
  endfunction

  function automatic logic [18:0] dut_f();
    return {cmd_fill, cmd_op, cmd_code, cmd_obj_type, cmd_obj_color, cmd_obj_num};
  endfunction

  // Advance the model with the inputs about to be sampled, then clock the DUT.
  task automatic tick();
    int     sz;
    bit     push_b, pop_b;
    entry_t e;
    sz = exp_q.size();
    if (!rst_n) begin
      exp_q.delete();
      exp_ovf = 1'b0;
      last    = '0;
    end else if (flush) begin
      exp_q.delete();
      exp_ovf = 1'b0;
    end else begin
      push_b = VPU_start && !STALL;
      pop_b  = (sz > 0) && cmd_ready;
      if (pop_b) void'(exp_q.pop_front());
      if (push_b) begin
        if (sz < int'(DEPTH) || pop_b) begin
          e.f = ref_decode(VPU_instr);
          e.v = V_in;
          exp_q.push_back(e);
        end else begin
          exp_ovf = 1'b1;
        end
      end
    end
    if (exp_q.size() > 0) last = exp_q[0];
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [15:0] instr, input logic [VW-1:0] v, input logic rdy);
    VPU_start = 1'b1;
    VPU_instr = instr;
    V_in      = v;
    cmd_ready = rdy;
    tick();
    VPU_start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; STALL = 1'b0; VPU_start = 1'b1; flush = 1'b0; cmd_ready = 1'b0;
    VPU_instr = 16'hA40D; V_in = rand_v();
    tick(); tick();
    rst_n = 1'b1; VPU_start = 1'b0;
    n_checks++;
    if (cmd_valid !== 1'b0 || count !== '0 || queue_full !== 1'b0 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: valid=%b count=%0d full=%b ovf=%b, required 0/0/0/0",
               cmd_valid, count, queue_full, overflow);
    end
    n_checks++;
    if (dut_f() !== 19'h0 || V_out !== '0) begin
      n_fail++;
      $display("FAIL reset_fields: fields=%h V_out=%h, required all zero", dut_f(), V_out);
    end
  endtask

  task automatic test_single_push();
    logic [VW-1:0] v;
    v = '0;
    v[15:0] = 16'h1234;
    push_one(16'hA40D, v, 1'b0);
    n_checks++;
    if (cmd_valid !== 1'b1 || cmd_op !== 4'd4 || cmd_code !== 4'b0111 || cmd_obj_num !== 5'h00) begin
      n_fail++;
      $display("FAIL single_push_fields: valid=%b op=%h code=%b num=%h, required 1/4/0111/00",
               cmd_valid, cmd_op, cmd_code, cmd_obj_num);
    end
    n_checks++;
    if (V_out[15:0] !== 16'h1234 || count !== CW'(1)) begin
      n_fail++;
      $display("FAIL single_push_data: word0=%h count=%0d, required 1234/1", V_out[15:0], count);
    end
    cmd_ready = 1'b1;
    tick();
    n_checks++;
    if (cmd_valid !== 1'b0 || count !== '0) begin
      n_fail++;
      $display("FAIL single_pop: valid=%b count=%0d, required 0/0", cmd_valid, count);
    end
  endtask

  task automatic test_decode_sweep();
    logic [15:0] instrs [16] = '{16'h8000, 16'h8800, 16'h9000, 16'h9C00, 16'h9800, 16'hA000,
                                 16'hA800, 16'hAC00, 16'hB000, 16'hB801, 16'hB802, 16'hB803,
                                 16'hC000, 16'hC400, 16'hC800, 16'hFFFF};
    logic [3:0]  ops    [16] = '{4'h0, 4'h0, 4'h0, 4'h2, 4'h1, 4'h3, 4'h7, 4'h6, 4'h5, 4'h8,
                                 4'h9, 4'hA, 4'hB, 4'hC, 4'hF, 4'h0};
    for (int k = 0; k < 16; k++) begin
      push_one(instrs[k], rand_v(), 1'b1);
      n_checks++;
      if (cmd_valid !== 1'b1 || cmd_op !== ops[k] || cmd_fill !== (k == 2)) begin
        n_fail++;
        $display("FAIL decode_%h: valid=%b op=%h fill=%b, required 1/%h/%b",
                 instrs[k], cmd_valid, cmd_op, cmd_fill, ops[k], k == 2);
      end
      n_checks++;
      if (dut_f() !== last.f || V_out !== last.v) begin
        n_fail++;
        $display("FAIL decode_model_%h: fields=%h, required %h", instrs[k], dut_f(), last.f);
      end
    end
    tick();
  endtask

  task automatic test_fill_overflow();
    logic [15:0]   ins [4];
    logic [VW-1:0] vs  [4];
    for (int k = 0; k < 4; k++) begin
      ins[k] = 16'($urandom);
      vs[k]  = rand_v();
      push_one(ins[k], vs[k], 1'b0);
    end
    n_checks++;
    if (queue_full !== 1'b1 || count !== CW'(4) || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL fill_full: full=%b count=%0d ovf=%b, required 1/4/0", queue_full, count, overflow);
    end
    push_one(16'($urandom), rand_v(), 1'b0);
    n_checks++;
    if (overflow !== 1'b1 || count !== CW'(4)) begin
      n_fail++;
      $display("FAIL overflow_set: ovf=%b count=%0d, required 1/4", overflow, count);
    end
    cmd_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (cmd_valid !== 1'b1 || dut_f() !== ref_decode(ins[k]) || V_out !== vs[k]) begin
        n_fail++;
        $display("FAIL drain_order_%0d: valid=%b fields=%h, required 1/%h",
                 k, cmd_valid, dut_f(), ref_decode(ins[k]));
      end
      tick();
    end
    n_checks++;
    if (cmd_valid !== 1'b0 || overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL drain_done: valid=%b ovf=%b, required 0/1 (sticky)", cmd_valid, overflow);
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_checks++;
    if (overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_clears_ovf: ovf=%b, required 0", overflow);
    end
  endtask

  task automatic test_full_push_pop();
    logic [15:0] last_in;
    for (int k = 0; k < 4; k++) push_one(16'($urandom), rand_v(), 1'b0);
    last_in = 16'hC400;
    push_one(last_in, rand_v(), 1'b1);
    n_checks++;
    if (count !== CW'(4) || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL full_push_pop: count=%0d ovf=%b, required 4/0", count, overflow);
    end
    cmd_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (dut_f() !== exp_q[0].f || V_out !== exp_q[0].v) begin
        n_fail++;
        $display("FAIL full_drain_%0d: fields=%h, required %h", k, dut_f(), exp_q[0].f);
      end
      if (k == 3) begin
        n_checks++;
        if (dut_f() !== ref_decode(last_in)) begin
          n_fail++;
          $display("FAIL full_last_out: fields=%h, required %h", dut_f(), ref_decode(last_in));
        end
      end
      tick();
    end
  endtask

  task automatic test_stall();
    for (int k = 0; k < 3; k++) push_one(16'($urandom), rand_v(), 1'b0);
    STALL = 1'b1; VPU_start = 1'b1; cmd_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_checks++;
      if (count !== CW'(3)) begin
        n_fail++;
        $display("FAIL stall_hold_%0d: count=%0d, required 3", k, count);
      end
    end
    cmd_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_checks++;
      if (count !== CW'(2 - k) || (k < 2 && dut_f() !== exp_q[0].f)) begin
        n_fail++;
        $display("FAIL stall_drain_%0d: count=%0d, required %0d", k, count, 2 - k);
      end
    end
    STALL = 1'b0; VPU_start = 1'b0;
  endtask

  task automatic test_flush_reset();
    for (int k = 0; k < 5; k++) push_one(16'($urandom), rand_v(), 1'b0);
    cmd_ready = 1'b1;
    tick();
    n_checks++;
    if (count !== CW'(3) || overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_flush: count=%0d ovf=%b, required 3/1", count, overflow);
    end
    flush = 1'b1;
    push_one(16'($urandom), rand_v(), 1'b1);
    flush = 1'b0;
    n_checks++;
    if (count !== '0 || cmd_valid !== 1'b0 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL flush: count=%0d valid=%b ovf=%b, required 0/0/0", count, cmd_valid, overflow);
    end
    for (int k = 0; k < 3; k++) push_one(16'($urandom), rand_v(), 1'b0);
    cmd_ready = 1'b1;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_checks++;
    if (count !== '0 || cmd_valid !== 1'b0 || overflow !== 1'b0 || dut_f() !== 19'h0) begin
      n_fail++;
      $display("FAIL mid_reset: count=%0d valid=%b ovf=%b fields=%h, required 0/0/0/0",
               count, cmd_valid, overflow, dut_f());
    end
  endtask

  task automatic test_random();
    int errs;
    errs = 0;
    for (int c = 0; c < 400; c++) begin
      VPU_start = ($urandom_range(0, 9) < 7);
      STALL     = ($urandom_range(0, 9) < 2);
      cmd_ready = ($urandom_range(0, 1) == 1);
      flush     = ($urandom_range(0, 31) == 0);
      VPU_instr = {5'(16 + $urandom_range(0, 10)), 11'($urandom)};
      V_in      = rand_v();
      tick();
      n_checks++;
      if (cmd_valid !== (exp_q.size() > 0) || count !== CW'(exp_q.size()) ||
          queue_full !== (exp_q.size() == int'(DEPTH)) || overflow !== exp_ovf ||
          dut_f() !== last.f || V_out !== last.v) begin
        n_fail++;
        if (errs++ < 10)
          $display("FAIL random_%0d: valid=%b count=%0d ovf=%b fields=%h, required %b/%0d/%b/%h",
                   c, cmd_valid, count, overflow, dut_f(),
                   exp_q.size() > 0, exp_q.size(), exp_ovf, last.f);
      end
    end
    VPU_start = 1'b0; STALL = 1'b0; flush = 1'b0;
  endtask

  initial begin
    exp_ovf = 1'b0;
    last    = '0;
    test_reset();
    test_single_push();
    test_decode_sweep();
    test_fill_overflow();
    test_full_push_pop();
    test_stall();
    test_flush_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vpu_cmd_queue.md
# vpu_cmd_queue

Parametrised successor to the single-stage VPU pipeline register: decodes each VPU instruction issued by the CPU and buffers it with its vector operand snapshot in a DEPTH-entry FIFO. Sits between the CPU decode/register-read stage and the VPU. Replaces the stall-hold register with a valid/ready handshake, so the CPU keeps issuing while the VPU is busy and stalls only on queue full. Adds flush and overflow detection.

## Interface
- DATA_W, 16, width of each operand word
- NUM_V, 8, vector operand words per command; the RO word is carried in addition
- DEPTH, 4, queue entries; power of two, minimum 2
- clk  in  1  system clock, rising edge
- rst_n  in  1  reset; **synchronous, active-low**
- STALL  in  1  CPU pipeline stall; no push while high
- VPU_start  in  1  CPU issues a VPU instruction this cycle
- VPU_instr  in  16  raw instruction
- V_in  in  (NUM_V+1)*DATA_W  operands; word i at bits [i*DATA_W +: DATA_W] for i < NUM_V, RO in the top word
- flush  in  1  discard all queued commands
- cmd_ready  in  1  VPU accepts the head command
- cmd_valid  out  1  head entry present
- cmd_fill, cmd_op[3:0], cmd_code[3:0], cmd_obj_type[1:0], cmd_obj_color[2:0], cmd_obj_num[4:0]  out  fields of the head entry
- V_out  out  (NUM_V+1)*DATA_W  operand snapshot of the head entry
- queue_full  out  1  count == DEPTH; goes to the hazard unit to raise STALL
- count  out  $clog2(DEPTH+1)  occupancy
- overflow  out  1  sticky: a push was dropped

## Operation
- Decode uses VPU_instr[15:11]. Defaults: fill=0, op=0, code={instr[1:0],instr[3:2]}.
- DRAW 10000 and ELLI 10001: op 0.
- FILL 10010: fill=1, op 0.
- RMV 10011: op = instr[10] ? 2 : 1.
- TRAN 10100: op = instr[10] ? 4 : 3.
- ROT 10101: op = instr[10] ? 6 : 7, code = instr[3:0].
- SCALE 10110: op 5, code = instr[3:0].
- REFLECT 10111: instr[1:0] = 1 gives op 8, 2 gives op 9, otherwise op A.
- MAT 11000: op = instr[10] ? C : B.
- GETOBJ 11001: op F.
- Any other opcode decodes as op 0, fill 0.
- Other fields: obj_type = instr[10:9], obj_num = instr[9:5], obj_color = instr[2:0].
- Decode is fully combinational with defaults assigned; it infers no latches.
- push = VPU_start & ~STALL & ~flush.
- pop = cmd_valid & cmd_ready & ~flush.
- A push is accepted when count < DEPTH, or when count == DEPTH and a pop occurs in the same cycle.
- A push that is not accepted is dropped and sets overflow. overflow clears only on reset or flush.
- FILL is enqueued like any other command with cmd_fill=1. The VPU uses cmd_fill to distinguish it; there is no separate start suppression.
- Outputs are show-ahead from the head entry. Output fields hold their last value when cmd_valid=0.
- flush: count, read pointer and write pointer go to 0 and overflow clears. A same-cycle push or pop is ignored. flush has priority over everything except reset.
- Pointers are log2(DEPTH) bits and wrap naturally.

## Timing
- Reset, sampled at a clk edge with rst_n=0: cmd_valid=0, queue_full=0, count=0, overflow=0, pointers 0, all cmd_* fields and V_out=0. Storage contents are don't-care.
- Reset mid-operation discards all entries exactly as flush does.
- Push-to-output latency is 1 cycle. A push at edge k into an empty queue gives cmd_valid=1 with the new fields after edge k. There is no combinational path from VPU_instr or V_in to any output.
- Pop takes effect at the edge where cmd_valid & cmd_ready are both high. The next entry, if any, appears after that edge.
- Simultaneous push and pop: count unchanged. At count 1 the pushed entry becomes head after the edge.
- queue_full and count are registered and valid from the cycle after each edge.
- STALL high: no push. The queue keeps draining to the VPU.
- cmd_ready is a don't-care while cmd_valid=0.

## Structure
- Package vpu_pkg holds:
  - the opcode constants (DRAW..GETOBJ)
  - the op encodings 0..F
  - a packed struct vpu_cmd_t {fill, op, code, obj_type, obj_color, obj_num}
  - the function vpu_decode(instr) returning vpu_cmd_t
- Sub-module vpu_instr_decode wraps vpu_decode and is the only decode site, so the VPU and the CPU hazard logic share a single definition.
- Storage is a register array of DEPTH entries of {vpu_cmd_t, operand words}, with read/write pointers and a count register.

## Test plan
- Reset then single push:
  - stimulus: TRAN 16'hA40D with V_in word0=16'h1234, cmd_ready=0
  - response: after one edge cmd_valid=1, op=4, code=4'b0111, obj_num=5'h00, V_out word0=16'h1234, count=1
- Decode sweep: one push per opcode with cmd_ready=1.
  - ROT instr[10]=0 gives op 7; REFLECT instr[1:0]=2 gives op 9; MAT instr[10]=1 gives op C; FILL gives cmd_fill=1, op 0; opcode 11111 gives op 0.
- Fill to DEPTH=4 with cmd_ready=0: queue_full=1.
  - A fifth push sets overflow=1 and leaves count at 4.
  - The head is still the first command, and draining yields the 4 commands in order.
- Full queue, push with cmd_ready=1 in the same cycle: count stays 4, overflow stays 0, and the new command emerges last.
- STALL=1 with VPU_start=1 for 3 cycles: count unchanged and the queue drains normally.
- flush with 3 entries plus a simultaneous push: next cycle count=0, cmd_valid=0, overflow=0. Reset asserted mid-drain gives the same result.
